// File: rtl/ascii_validator.sv
// Captures one payload packet into a parallel character buffer and flags
// any byte outside the numeric-text alphabet (digits, space, minus) or overflow.
module ascii_validator #(
  parameter int MAX_PAYLOAD = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  input  logic        payload_last,
  output logic        payload_ready,
  output logic [7:0]  char_buffer [0:MAX_PAYLOAD-1],
  output logic [15:0] buffer_length,
  output logic        done,
  output logic        invalid
);

  localparam int          IDX_W   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic {
    RECV = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic               inv_q, inv_d;
  logic [15:0]        base_len_s;
  logic               base_inv_s;
  logic               accept_s;
  logic               wr_en_s;
  logic [IDX_W-1:0]   wr_idx_s;

  function automatic logic is_allowed(input logic [7:0] b);
    is_allowed = ((b >= 8'h30) && (b <= 8'h39)) || (b == 8'h20) || (b == 8'h2D);
  endfunction

  assign payload_ready = ~rst;
  assign accept_s      = payload_valid & payload_ready;
  assign buffer_length = len_q;
  assign invalid       = inv_q;
  assign done          = (state_q == DONE);

  // A byte arriving in DONE restarts the packet, so it sees a cleared length and flag.
  always_comb begin
    base_len_s = len_q;
    base_inv_s = inv_q;
    case (state_q)
      RECV: begin
        base_len_s = len_q;
        base_inv_s = inv_q;
      end
      DONE: begin
        base_len_s = 16'd0;
        base_inv_s = 1'b0;
      end
      default: begin
        base_len_s = 16'd0;
        base_inv_s = 1'b0;
      end
    endcase
  end

  // Next-state, length and sticky invalid flag.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    inv_d    = inv_q;
    wr_en_s  = 1'b0;
    wr_idx_s = base_len_s[IDX_W-1:0];
    if (accept_s) begin
      if (base_len_s < MAX_LEN) begin
        wr_en_s = 1'b1;
        len_d   = base_len_s + 16'd1;
        inv_d   = base_inv_s | ~is_allowed(payload_data);
      end else begin
        wr_en_s = 1'b0;
        len_d   = base_len_s;
        inv_d   = 1'b1;
      end
      if (payload_last) begin
        state_d = DONE;
      end else begin
        state_d = RECV;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RECV;
      len_q   <= 16'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      inv_q   <= inv_d;
    end
  end

  // Buffer storage is intentionally not reset; entries past the length are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      char_buffer[wr_idx_s] <= payload_data;
    end
  end

endmodule

// File: tb/tb_ascii_validator.sv
// Directed bench for ascii_validator: two instances (deep and 4-byte buffer)
// share one input stream and are checked against a packet-level model.
module tb_ascii_validator;

  localparam int BIG   = 32;
  localparam int SMALL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  payload_data = 8'h00;
  logic        payload_valid = 1'b0;
  logic        payload_last = 1'b0;

  logic        ready_big, ready_small;
  logic [7:0]  buf_big   [0:BIG-1];
  logic [7:0]  buf_small [0:SMALL-1];
  logic [15:0] len_big, len_small;
  logic        done_big, done_small;
  logic        inv_big, inv_small;

  int checks = 0;
  int failures = 0;

  ascii_validator #(.MAX_PAYLOAD(BIG)) dut (
    .clk(clk), .rst(rst), .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_last(payload_last), .payload_ready(ready_big), .char_buffer(buf_big),
    .buffer_length(len_big), .done(done_big), .invalid(inv_big)
  );

  ascii_validator #(.MAX_PAYLOAD(SMALL)) dut_small (
    .clk(clk), .rst(rst), .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_last(payload_last), .payload_ready(ready_small), .char_buffer(buf_small),
    .buffer_length(len_small), .done(done_small), .invalid(inv_small)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: byte list per instance, done/invalid flags.
  int         cap [2] = '{BIG, SMALL};
  logic [7:0] mbuf [2][0:BIG-1];
  int         mlen [2] = '{0, 0};
  logic       mdone [2] = '{1'b0, 1'b0};
  logic       minv [2] = '{1'b0, 1'b0};

  function automatic logic allowed(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || b == 8'h20 || b == 8'h2D;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mlen[k] = 0; mdone[k] = 1'b0; minv[k] = 1'b0;
      end
    end else if (payload_valid) begin
      for (int k = 0; k < 2; k++) begin
        if (mdone[k]) begin
          mlen[k] = 0; minv[k] = 1'b0; mdone[k] = 1'b0;
        end
        if (mlen[k] < cap[k]) begin
          mbuf[k][mlen[k]] = payload_data;
          mlen[k] = mlen[k] + 1;
          if (!allowed(payload_data)) minv[k] = 1'b1;
        end else begin
          minv[k] = 1'b1;
        end
        if (payload_last) mdone[k] = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("ready_big", ready_big, !rst);
    chk("ready_small", ready_small, !rst);
    chk("len_big", len_big, mlen[0]);
    chk("done_big", done_big, mdone[0]);
    chk("inv_big", inv_big, minv[0]);
    chk("len_small", len_small, mlen[1]);
    chk("done_small", done_small, mdone[1]);
    chk("inv_small", inv_small, minv[1]);
    for (int i = 0; i < mlen[0]; i++)
      if (buf_big[i] !== mbuf[0][i]) chk($sformatf("buf_big[%0d]", i), buf_big[i], mbuf[0][i]);
    for (int i = 0; i < mlen[1]; i++)
      if (buf_small[i] !== mbuf[1][i]) chk($sformatf("buf_small[%0d]", i), buf_small[i], mbuf[1][i]);
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    @(negedge clk);
    payload_data = b; payload_valid = 1'b1; payload_last = l;
    @(posedge clk);
    #1;
    payload_valid = 1'b0; payload_last = 1'b0;
  endtask

  // Idle cycles with a stray last and a disallowed byte on the bus that must be ignored.
  task automatic idle(input int n);
    @(negedge clk);
    payload_data = 8'h41; payload_last = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    payload_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], i == s.len() - 1);
      if (gaps) idle($urandom_range(1, 3));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_done", done_big, 1'b0);
    chk("rst_len", len_big, 16'd0);
    chk("rst_inv", inv_big, 1'b0);
    chk("rst_ready", ready_big, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic check_pkt(input string name, input string exp, input int exp_len, input logic exp_inv);
    @(negedge clk);
    #1;
    chk({name, "_done"}, done_big, 1'b1);
    chk({name, "_len"}, len_big, exp_len);
    chk({name, "_inv"}, inv_big, exp_inv);
    for (int i = 0; i < exp.len(); i++)
      chk($sformatf("%s_buf[%0d]", name, i), buf_big[i], exp[i]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("init_len", len_big, 16'd0);
    chk("init_done", done_big, 1'b0);
    chk("init_inv", inv_big, 1'b0);
    chk("init_ready", ready_big, 1'b0);
    #1 rst = 1'b0;

    send_str("123456789", 1'b0);
    check_pkt("digits", "123456789", 9, 1'b0);

    send_str("-123 456 -789", 1'b0);
    check_pkt("mixed1", "-123 456 -789", 13, 1'b0);
    do_reset();
    send_str("  -100 0 200  -300  ", 1'b0);
    check_pkt("mixed2", "  -100 0 200  -300  ", 20, 1'b0);

    do_reset();
    send_str("123ABC456", 1'b0);
    check_pkt("letters", "123ABC456", 9, 1'b1);
    do_reset();
    send_str("123!456", 1'b0);
    check_pkt("bang", "123!456", 7, 1'b1);
    do_reset();
    send_str("123.456", 1'b0);
    check_pkt("dot", "123.456", 7, 1'b1);
    do_reset();
    send_str("12+34=46", 1'b0);
    check_pkt("plus", "12+34=46", 8, 1'b1);

    do_reset();
    send_byte(8'h00, 1'b1);
    check_pkt("nul", "", 1, 1'b1);
    chk("nul_byte", buf_big[0], 8'h00);

    do_reset();
    send_str("0 0 0 0", 1'b1);
    check_pkt("gaps", "0 0 0 0", 7, 1'b0);

    do_reset();
    send_str("12345-", 1'b0);
    check_pkt("ovf_big", "12345-", 6, 1'b0);
    chk("ovf_small_done", done_small, 1'b1);
    chk("ovf_small_len", len_small, 16'd4);
    chk("ovf_small_inv", inv_small, 1'b1);
    chk("ovf_small_b0", buf_small[0], 8'h31);
    chk("ovf_small_b1", buf_small[1], 8'h32);
    chk("ovf_small_b2", buf_small[2], 8'h33);
    chk("ovf_small_b3", buf_small[3], 8'h34);

    send_str("12", 1'b0);
    check_pkt("b2b1", "12", 2, 1'b0);
    send_str("34", 1'b0);
    check_pkt("b2b2", "34", 2, 1'b0);
    chk("b2b_small_len", len_small, 16'd2);
    chk("b2b_small_inv", inv_small, 1'b0);

    send_byte(8'h35, 1'b0);
    send_byte(8'h36, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_done", done_big, 1'b0);
    chk("mid_len", len_big, 16'd2);
    do_reset();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
